// File: rtl/sub_bytes_seq_pkg.sv
// Shared definitions for the byte-serial AES round sequencers
// (SubBytes now, ShiftRows/MixColumns later).
package sub_bytes_seq_pkg;

    localparam int NBYTES  = 16;
    localparam int STATE_W = 128;
    localparam int CNT_W   = $clog2(NBYTES) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } seq_state_e;

    // Byte k of a state, byte 0 being the most significant byte.
    function automatic logic [7:0] state_byte(input logic [STATE_W-1:0] s,
                                              input logic [CNT_W-1:0]   k);
        return s[STATE_W-1-8*int'(k) -: 8];
    endfunction

endpackage

// File: rtl/sub_bytes_seq_if.sv
// Byte-wide link between the SubBytes sequencer (master) and the s_box unit (slave).
interface sub_bytes_seq_if;

    logic [7:0] sb_in;
    logic       sb_ready;
    logic       sb_encrypt;
    logic [7:0] sb_out;
    logic       sb_done;

    modport master (
        output sb_in,
        output sb_ready,
        output sb_encrypt,
        input  sb_out,
        input  sb_done
    );

    modport slave (
        input  sb_in,
        input  sb_ready,
        input  sb_encrypt,
        output sb_out,
        output sb_done
    );

endinterface

// File: rtl/sub_bytes_seq.sv
// Serialises a 128-bit state through the byte-wide s_box one byte per clock
// and reassembles the substituted bytes into state_out.
module sub_bytes_seq
    import sub_bytes_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               encrypt,
    input  logic [STATE_W-1:0] state_in,
    output logic [STATE_W-1:0] state_out,
    output logic               done,
    output logic               busy,
    sub_bytes_seq_if.master    sb
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] RX_FULL  = CNT_W'(NBYTES);

    seq_state_e         state_q;
    seq_state_e         state_d;
    logic [CNT_W-1:0]   tx_cnt;
    logic [CNT_W-1:0]   rx_cnt;
    logic [STATE_W-1:0] issue_reg;
    logic [STATE_W-1:0] shadow;

    logic accept;
    logic advance;
    logic last_tx;
    logic capture;
    logic finish;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Results are counted by sb_done alone, so a stalled s_box only stretches DRAIN.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        advance = 1'b0;
        last_tx = 1'b0;
        finish  = 1'b0;
        capture = (state_q != IDLE) && sb.sb_done && (rx_cnt < RX_FULL);

        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (tx_cnt == LAST_IDX) begin
                    last_tx = 1'b1;
                    state_d = DRAIN;
                end else begin
                    advance = 1'b1;
                end
            end
            DRAIN: begin
                if (capture && (rx_cnt == LAST_IDX)) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_reg     <= '0;
            tx_cnt        <= '0;
            sb.sb_in      <= '0;
            sb.sb_ready   <= 1'b0;
            sb.sb_encrypt <= 1'b0;
        end else begin
            if (accept) begin
                issue_reg     <= state_in;
                tx_cnt        <= '0;
                sb.sb_in      <= state_byte(state_in, '0);
                sb.sb_ready   <= 1'b1;
                sb.sb_encrypt <= encrypt;
            end
            if (advance) begin
                tx_cnt   <= tx_cnt + CNT_W'(1);
                sb.sb_in <= state_byte(issue_reg, tx_cnt + CNT_W'(1));
            end
            if (last_tx) begin
                sb.sb_ready <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_cnt <= '0;
            shadow <= '0;
        end else begin
            if (accept) begin
                rx_cnt <= '0;
            end else if (capture) begin
                shadow[STATE_W-1-8*int'(rx_cnt) -: 8] <= sb.sb_out;
                rx_cnt <= rx_cnt + CNT_W'(1);
            end
        end
    end

    // The final byte bypasses the shadow so state_out is ready in the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_out <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                busy <= 1'b1;
            end
            if (finish) begin
                state_out <= {shadow[STATE_W-1:8], sb.sb_out};
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: behavioural s_box with optional stalls, a
// transaction-level model of the sequencer, and directed scenarios.
module tb_sub_bytes_seq;
    import sub_bytes_seq_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         encrypt = 1'b0;
    logic [127:0] state_in = '0;
    logic [127:0] state_out;
    logic         done;
    logic         busy;

    sub_bytes_seq_if sbif();

    sub_bytes_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .encrypt  (encrypt),
        .state_in (state_in),
        .state_out(state_out),
        .done     (done),
        .busy     (busy),
        .sb       (sbif)
    );

    always #5 clk = ~clk;

    int nAsserts = 0;
    int nFails   = 0;
    int cyc      = 0;
    bit checkEn  = 0;

    logic [7:0] sbox    [256];
    logic [7:0] invSbox [256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nAsserts++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [127:0] subBytesModel(input logic [127:0] st, input logic enc);
        logic [127:0] r = '0;
        logic [7:0]   b;
        for (int k = 0; k < 16; k++) begin
            b = st[127-8*k -: 8];
            r[127-8*k -: 8] = enc ? sbox[b] : invSbox[b];
        end
        return r;
    endfunction

    // s_box stand-in: results queue up with a release cycle; stallMode adds
    // 3 cycles of latency plus a 2-cycle gap from the ninth byte onward.
    typedef struct {
        logic [7:0] val;
        int         readyAt;
    } sbRes_t;

    sbRes_t     sbQ[$];
    int         issueIdx = 0;
    bit         stallMode = 0;
    bit         strayReq = 0;
    logic [7:0] strayVal = 8'h00;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sbQ.delete();
            issueIdx     <= 0;
            sbif.sb_done <= 1'b0;
            sbif.sb_out  <= 8'h00;
        end else begin
            if (sbif.sb_ready) begin
                sbQ.push_back(sbRes_t'{(sbif.sb_encrypt ? sbox[sbif.sb_in] : invSbox[sbif.sb_in]),
                                       cyc + (stallMode ? ((issueIdx >= 8) ? 5 : 3) : 0)});
                issueIdx <= issueIdx + 1;
            end else begin
                issueIdx <= 0;
            end
            sbif.sb_done <= 1'b0;
            if (strayReq) begin
                sbif.sb_done <= 1'b1;
                sbif.sb_out  <= strayVal;
            end else if (sbQ.size() > 0 && sbQ[0].readyAt <= cyc) begin
                sbif.sb_done <= 1'b1;
                sbif.sb_out  <= sbQ[0].val;
                sbQ.delete(0);
            end
        end
    end

    // Transaction model: an accepted start yields done and the substituted
    // state 17 cycles later (plus any s_box stall).
    logic         mBusy, mDone, mEnc;
    logic [127:0] mOut, mPending;
    int           mDoneAt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mBusy <= 1'b0;
            mDone <= 1'b0;
            mEnc  <= 1'b0;
            mOut  <= '0;
        end else begin
            mDone <= mBusy && (cyc == mDoneAt);
            if (mBusy) begin
                if (cyc == mDoneAt) begin
                    mBusy <= 1'b0;
                    mOut  <= mPending;
                end
            end else if (start) begin
                mBusy    <= 1'b1;
                mEnc     <= encrypt;
                mPending <= subBytesModel(state_in, encrypt);
                mDoneAt  <= cyc + 17 + (stallMode ? 5 : 0);
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cyc_done", done, mDone);
            checkOutput("cyc_busy", busy, mBusy);
            checkOutput("cyc_state_out", state_out, mOut);
            if (mBusy) checkOutput("cyc_sb_encrypt", sbif.sb_encrypt, mEnc);
        end
    end

    task automatic applyStimulus(input logic [127:0] st, input logic enc);
        start    = 1'b1;
        state_in = st;
        encrypt  = enc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int maxCyc, input int expLat);
        int lat  = 0;
        bit seen = 0;
        while (!seen && lat < maxCyc) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) seen = 1;
        end
        checkOutput({name, "_done_seen"}, 128'(seen), 128'd1);
        if (seen) checkOutput({name, "_latency"}, 128'(lat), 128'(expLat));
    endtask

    task automatic countDones(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
    endtask

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h638293c31bfc33f5c4eeacea4bc12816;

    initial begin
        int pulses;
        logic [7:0] inv;

        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256 && a != 0; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            invSbox[sbox[a]] = 8'(a);
        end
        checkOutput("pin_sbox_00", sbox[8'h00], 8'h63);
        checkOutput("pin_sbox_01", sbox[8'h01], 8'h7c);
        checkOutput("pin_sbox_53", sbox[8'h53], 8'hed);
        checkOutput("pin_inv_16", invSbox[8'h16], 8'hff);

        #1 reset = 1'b1;
        #1;
        checkOutput("rst_state_out", state_out, '0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_sb_in", sbif.sb_in, 0);
        checkOutput("rst_sb_ready", sbif.sb_ready, 0);
        checkOutput("rst_sb_encrypt", sbif.sb_encrypt, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checkEn = 1;
        @(posedge clk);
        #1;

        $display("[TB] scenario 1: encrypt");
        applyStimulus(PT, 1'b1);
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_sb_encrypt", sbif.sb_encrypt, 1);
        waitDone("t1", 40, 17);
        checkOutput("t1_result", state_out, CT);

        $display("[TB] scenario 3: back-to-back and start while busy");
        applyStimulus('0, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checkOutput("t3_hold_first", state_out, CT);
        start    = 1'b1;
        state_in = {16{8'hff}};
        encrypt  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone("t3", 40, 11);
        checkOutput("t3_result", state_out, {16{8'h63}});
        countDones(20, pulses);
        checkOutput("t3_no_extra_done", 128'(pulses), 0);
        checkOutput("t3_result_kept", state_out, {16{8'h63}});

        $display("[TB] scenario 2: decrypt");
        applyStimulus(CT, 1'b0);
        waitDone("t2", 40, 17);
        checkOutput("t2_result", state_out, PT);

        $display("[TB] scenario 4: reset mid-operation");
        applyStimulus(PT, 1'b1);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        #1 reset = 1'b1;
        #1;
        checkOutput("t4_state_out", state_out, '0);
        checkOutput("t4_done", done, 0);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_sb_in", sbif.sb_in, 0);
        checkOutput("t4_sb_ready", sbif.sb_ready, 0);
        checkOutput("t4_sb_encrypt", sbif.sb_encrypt, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        strayReq = 1;
        strayVal = 8'h5a;
        @(posedge clk);
        #1 strayReq = 0;
        countDones(25, pulses);
        checkOutput("t4_stray_no_done", 128'(pulses), 0);
        checkOutput("t4_stray_state_out", state_out, '0);
        applyStimulus(PT, 1'b1);
        waitDone("t4", 40, 17);
        checkOutput("t4_result", state_out, CT);

        $display("[TB] scenario 5: stalled s_box");
        stallMode = 1;
        applyStimulus({16{8'h01}}, 1'b1);
        waitDone("t5", 60, 22);
        checkOutput("t5_result", state_out, {16{8'h7c}});
        stallMode = 0;

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
